l1_refill_ctrl: RTL and testbench
=================================

L1_REFILL_CTRL -- requirements
Module: l1_refill_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, word width; LINE_SIZE, default 16, line bytes (4 words).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mem_valid  input  1  CPU access present.
REQ-005 mem_we  input  1  CPU access is a store.
REQ-006 mem_addr  input  ADDR_WIDTH  CPU byte address (word-aligned).
REQ-007 mem_w_data  input  DATA_WIDTH  CPU store data.
REQ-008 cache_hit  input  1  hit indication from the L1 data array.
REQ-009 stall  output  1  hold CPU; access not complete.
REQ-010 fill_en  output  1  write one word into the L1 line.
REQ-011 fill_addr  output  ADDR_WIDTH  address of the word being filled.
REQ-012 fill_data  output  DATA_WIDTH  fill word.
REQ-013 fill_mark_valid  output  1  set tag/valid of the line (last word only).
REQ-014 bus_req_valid  output  1  memory request present.
REQ-015 bus_req_ready  input  1  memory accepts request this cycle.
REQ-016 bus_req_we  output  1  request is a write.
REQ-017 bus_req_addr  output  ADDR_WIDTH  request word address.
REQ-018 bus_req_wdata  output  DATA_WIDTH  write data.
REQ-019 bus_resp_valid  input  1  read data returned (reads only, in order, one per request).
REQ-020 bus_resp_data  input  DATA_WIDTH  read data.

Function
REQ-021 Policy SHALL be write-through, no-write-allocate; read miss fills a whole line.
REQ-022 States SHALL be IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE.
REQ-023 IDLE: mem_valid&!mem_we&cache_hit -> stall=0, stay IDLE (zero-cycle hit).
REQ-024 IDLE: mem_valid&!mem_we&!cache_hit -> stall=1, latch line base (mem_addr with low log2(LINE_SIZE) bits cleared) and start word, go RD_REQ.
REQ-025 IDLE: mem_valid&mem_we (hit or miss) -> stall=1, latch addr/data, go WR_REQ.
REQ-026 WR_REQ: bus_req_valid=1, we=1, latched addr/data held stable; on bus_req_ready go DONE.
REQ-027 RD_REQ: bus_req_valid=1, we=0, addr=line base+4*word counter; on bus_req_ready go RD_WAIT.
REQ-028 RD_WAIT: on bus_resp_valid, fill_en=1 same cycle (combinational), fill_data=bus_resp_data, fill_addr=request address; counter increments mod 4; if 4th word, fill_mark_valid=1 and go IDLE, else RD_REQ.
REQ-029 At most one bus request outstanding; bus_req_valid SHALL NOT drop before bus_req_ready.
REQ-030 stall SHALL be 1 in WR_REQ, RD_REQ, RD_WAIT; 0 in DONE.
REQ-031 DONE: stall=0, no new access accepted regardless of inputs, next state IDLE (prevents re-issuing the completing store).
REQ-032 After final fill, IDLE re-evaluates: cache_hit now 1, so stall=0 that cycle; minimum read-miss penalty with 0-wait memory = 8 cycles + 1.
REQ-033 bus_resp_valid outside RD_WAIT SHALL be ignored; fill_en=0 outside RD_WAIT.
REQ-034 Word counter SHALL wrap 3->0; exactly 4 fills per miss, each distinct word.

Reset
REQ-035 rst SHALL force IDLE, counter 0, latches 0; outputs stall=0, fill_en=0, fill_mark_valid=0, bus_req_valid=0, bus_req_we=0, all address/data outputs 0.
REQ-036 rst mid-refill SHALL abandon the line without fill_mark_valid; a late bus_resp_valid after reset SHALL be ignored.

Configuration
REQ-037 Macro L1_CRITICAL_WORD_FIRST_EN defined: refill starts at the missed word (mem_addr[3:2]) and wraps; undefined: refill always starts at word 0.

Structure
REQ-038 Shared package l1_pkg SHALL hold the state enum, LINE_SIZE, WORDS_PER_LINE, word-offset bit constants; same package used by the L1 data array.
REQ-039 Block SHALL be flat; no sub-module.

Verification
REQ-040 Read hit: mem_valid=1, we=0, cache_hit=1 -> stall=0, no bus_req_valid.
REQ-041 Read miss 0x0000_1238, ready=1, resp 1 cycle later -> fills 0x1230,0x1234,0x1238,0x123C (CWF off) or 0x1238,0x123C,0x1230,0x1234 (CWF on); fill_mark_valid only on 4th.
REQ-042 Store 0x100<=0xDEADBEEF, ready low 3 cycles -> request held stable 4 cycles, stall=1, then DONE with stall=0 and a single bus write.
REQ-043 Store miss -> one bus write, zero fills.
REQ-044 rst after 2nd fill word -> IDLE, all outputs 0, stray bus_resp_valid produces no fill_en.

Source files
------------

// File: rtl/l1_pkg.sv
// Shared L1 cache definitions: line geometry, word-offset bit positions and the
// refill controller state encoding. Also used by the L1 data array.
package l1_pkg;

   localparam int LINE_SIZE      = 16;
   localparam int WORD_BYTES     = 4;
   localparam int WORDS_PER_LINE = LINE_SIZE / WORD_BYTES;

   // Byte address layout inside a line: [OFFSET_BITS-1:WORD_LSB] selects the word.
   localparam int WORD_LSB    = $clog2(WORD_BYTES);
   localparam int OFFSET_BITS = $clog2(LINE_SIZE);
   localparam int WORD_MSB    = OFFSET_BITS - 1;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      RD_REQ,
      RD_WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/l1_refill_ctrl.sv
// Write-through, no-write-allocate L1 refill controller with whole-line read fills.
// Build option: define L1_CRITICAL_WORD_FIRST_EN to start each refill at the missed word.
module l1_refill_ctrl
   import l1_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_SIZE  = l1_pkg::LINE_SIZE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_valid,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_w_data,
   input  logic                  cache_hit,
   output logic                  stall,
   output logic                  fill_en,
   output logic [ADDR_WIDTH-1:0] fill_addr,
   output logic [DATA_WIDTH-1:0] fill_data,
   output logic                  fill_mark_valid,
   output logic                  bus_req_valid,
   input  logic                  bus_req_ready,
   output logic                  bus_req_we,
   output logic [ADDR_WIDTH-1:0] bus_req_addr,
   output logic [DATA_WIDTH-1:0] bus_req_wdata,
   input  logic                  bus_resp_valid,
   input  logic [DATA_WIDTH-1:0] bus_resp_data
);

   localparam int OFF_BITS = $clog2(LINE_SIZE);
   localparam int IDX_BITS = OFF_BITS - WORD_LSB;
   localparam int WORDS    = LINE_SIZE / WORD_BYTES;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [IDX_BITS-1:0]   idx_q;
   logic [IDX_BITS-1:0]   beats_q;
   logic [IDX_BITS-1:0]   start_idx;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  last_beat;

`ifdef L1_CRITICAL_WORD_FIRST_EN
   assign start_idx = mem_addr[OFF_BITS-1:WORD_LSB];
`else
   assign start_idx = '0;
`endif

   // idx_q walks the line (and may wrap); beats_q counts fills, so the last
   // fill is known independently of where the refill started.
   assign rd_addr   = {addr_q[ADDR_WIDTH-1:OFF_BITS], idx_q, {WORD_LSB{1'b0}}};
   assign last_beat = (beats_q == IDX_BITS'(WORDS - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (mem_valid) begin
               if (mem_we)          state_d = WR_REQ;
               else if (!cache_hit) state_d = RD_REQ;
            end
         end
         WR_REQ:  if (bus_req_ready) state_d = DONE;
         RD_REQ:  if (bus_req_ready) state_d = RD_WAIT;
         RD_WAIT: if (bus_resp_valid) state_d = last_beat ? IDLE : RD_REQ;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         beats_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (mem_valid && mem_we) begin
                  addr_q <= mem_addr;
                  data_q <= mem_w_data;
               end else if (mem_valid && !cache_hit) begin
                  addr_q  <= {mem_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
                  idx_q   <= start_idx;
                  beats_q <= '0;
               end
            end
            RD_WAIT: begin
               if (bus_resp_valid) begin
                  idx_q   <= idx_q + 1'b1;
                  beats_q <= beats_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are forced low during reset, including the zero-cycle IDLE stall.
   always_comb begin
      stall           = 1'b0;
      fill_en         = 1'b0;
      fill_addr       = '0;
      fill_data       = '0;
      fill_mark_valid = 1'b0;
      bus_req_valid   = 1'b0;
      bus_req_we      = 1'b0;
      bus_req_addr    = '0;
      bus_req_wdata   = '0;
      if (!rst) begin
         unique case (state_q)
            IDLE: stall = mem_valid && (mem_we || !cache_hit);
            WR_REQ: begin
               stall         = 1'b1;
               bus_req_valid = 1'b1;
               bus_req_we    = 1'b1;
               bus_req_addr  = addr_q;
               bus_req_wdata = data_q;
            end
            RD_REQ: begin
               stall         = 1'b1;
               bus_req_valid = 1'b1;
               bus_req_addr  = rd_addr;
            end
            RD_WAIT: begin
               stall = 1'b1;
               if (bus_resp_valid) begin
                  fill_en         = 1'b1;
                  fill_addr       = rd_addr;
                  fill_data       = bus_resp_data;
                  fill_mark_valid = last_beat;
               end
            end
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Self-checking bench for l1_refill_ctrl: transaction-level model of expected bus
// requests and line fills, a simple memory responder, and directed access scenarios.
module tb_l1_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_we, cache_hit;
   logic [31:0] mem_addr, mem_w_data;
   logic        stall, fill_en, fill_mark_valid;
   logic [31:0] fill_addr, fill_data;
   logic        bus_req_valid, bus_req_ready, bus_req_we;
   logic [31:0] bus_req_addr, bus_req_wdata;
   logic        bus_resp_valid;
   logic [31:0] bus_resp_data;

   always #5 clk = ~clk;

   l1_refill_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_valid      (mem_valid),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_w_data     (mem_w_data),
      .cache_hit      (cache_hit),
      .stall          (stall),
      .fill_en        (fill_en),
      .fill_addr      (fill_addr),
      .fill_data      (fill_data),
      .fill_mark_valid(fill_mark_valid),
      .bus_req_valid  (bus_req_valid),
      .bus_req_ready  (bus_req_ready),
      .bus_req_we     (bus_req_we),
      .bus_req_addr   (bus_req_addr),
      .bus_req_wdata  (bus_req_wdata),
      .bus_resp_valid (bus_resp_valid),
      .bus_resp_data  (bus_resp_data)
   );

`ifdef L1_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        mark;
   } fill_t;

   req_t        exp_req[$];
   fill_t       exp_fill[$];
   logic [31:0] fill_log[$];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fill = 0, n_mark = 0, n_wr = 0, n_req_cycles = 0;
   int ready_delay = 0;
   int inject_cnt  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Backing memory contents as seen by the bus.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
   endfunction

   // A read miss produces four word reads covering the whole line, in order from
   // the start word with wrap-around, each followed by one fill; only the 4th marks.
   task automatic push_read_miss(input logic [31:0] a);
      logic [31:0] base, wa;
      int          start, w;
      base  = a & ~32'hF;
      start = CWF ? int'(a[3:2]) : 0;
      for (int k = 0; k < 4; k++) begin
         w  = (start + k) % 4;
         wa = base + 32'(4 * w);
         exp_req.push_back('{1'b0, wa, 32'h0});
         exp_fill.push_back('{wa, mem_word(wa), (k == 3)});
      end
   endtask

   // Memory responder: ready after ready_delay wait cycles, read data one cycle later.
   initial begin
      logic        resp_pending;
      logic [31:0] resp_addr;
      int          wait_cnt, inject_seen;
      resp_pending = 1'b0; resp_addr = '0; wait_cnt = 0; inject_seen = 0;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0;
      forever begin
         @(posedge clk); #2;
         bus_resp_valid = 1'b0;
         bus_resp_data  = '0;
         if (resp_pending) begin
            bus_resp_valid = 1'b1;
            bus_resp_data  = mem_word(resp_addr);
            resp_pending   = 1'b0;
         end else if (inject_cnt != inject_seen) begin
            bus_resp_valid = 1'b1;
            bus_resp_data  = 32'hBAD0_BAD0;
            inject_seen    = inject_cnt;
         end
         bus_req_ready = 1'b0;
         if (bus_req_valid) begin
            if (wait_cnt >= ready_delay) begin
               bus_req_ready = 1'b1;
               wait_cnt      = 0;
               if (!bus_req_we) begin
                  resp_pending = 1'b1;
                  resp_addr    = bus_req_addr;
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Per-cycle comparison of DUT bus and fill activity against the model queues.
   always @(negedge clk) begin
      static logic prev_wait = 1'b0;
      if (rst) begin
         check("reset_outputs_zero",
               64'(|{stall, fill_en, fill_mark_valid, bus_req_valid, bus_req_we,
                     fill_addr, fill_data, bus_req_addr, bus_req_wdata}), 64'd0);
         exp_req.delete();
         exp_fill.delete();
         prev_wait = 1'b0;
      end else begin
         if (prev_wait) check("req_held_until_ready", bus_req_valid, 1'b1);
         if (bus_req_valid) begin
            n_req_cycles++;
            check("req_expected_by_model", 64'(exp_req.size() != 0), 64'd1);
            if (exp_req.size() != 0) begin
               check("req_we", bus_req_we, exp_req[0].we);
               check("req_addr", bus_req_addr, exp_req[0].addr);
               if (exp_req[0].we) check("req_wdata", bus_req_wdata, exp_req[0].data);
               if (bus_req_ready) begin
                  if (exp_req[0].we) n_wr++;
                  void'(exp_req.pop_front());
               end
            end
         end
         prev_wait = bus_req_valid && !bus_req_ready;
         if (fill_en) begin
            n_fill++;
            if (fill_mark_valid) n_mark++;
            fill_log.push_back(fill_addr);
            check("fill_expected_by_model", 64'(exp_fill.size() != 0), 64'd1);
            if (exp_fill.size() != 0) begin
               check("fill_addr", fill_addr, exp_fill[0].addr);
               check("fill_data", fill_data, exp_fill[0].data);
               check("fill_mark_valid", fill_mark_valid, exp_fill[0].mark);
               void'(exp_fill.pop_front());
            end
         end else begin
            if (fill_mark_valid) check("mark_without_fill", fill_mark_valid, 1'b0);
         end
      end
   end

   // One CPU access: hold it until stall drops; the data array reports a hit
   // once the line has been marked valid.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic hit, output int stalls);
      logic set_hit, done;
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_we = we; mem_addr = addr; mem_w_data = data; cache_hit = hit;
      stalls = 0; done = 1'b0; set_hit = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
            break;
         end
         stalls++;
         if (fill_mark_valid) set_hit = 1'b1;
         @(posedge clk); #1;
         if (set_hit) cache_hit = 1'b1;
      end
      check("access_completes", done, 1'b1);
      @(posedge clk); #1;
      mem_valid = 1'b0; mem_we = 1'b0; cache_hit = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_order[4];
      int st, f0, m0, w0, r0, l0;
      logic got;
      if (CWF) begin
         exp_order[0] = 32'h1238; exp_order[1] = 32'h123C;
         exp_order[2] = 32'h1230; exp_order[3] = 32'h1234;
      end else begin
         exp_order[0] = 32'h1230; exp_order[1] = 32'h1234;
         exp_order[2] = 32'h1238; exp_order[3] = 32'h123C;
      end
      rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_w_data = '0;
      cache_hit = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_stall", stall, 1'b0);
      check("idle_req_valid", bus_req_valid, 1'b0);
      check("idle_fill_en", fill_en, 1'b0);

      // Read hit: zero-cycle, no bus traffic.
      r0 = n_req_cycles;
      access(1'b0, 32'h0000_0040, 32'h0, 1'b1, st);
      check("hit_stalls", st, 0);
      check("hit_no_bus", n_req_cycles - r0, 0);

      // Read miss, zero-wait memory: 9 stalled cycles, 4 fills, one mark.
      ready_delay = 0; f0 = n_fill; m0 = n_mark; l0 = fill_log.size();
      push_read_miss(32'h0000_1238);
      access(1'b0, 32'h0000_1238, 32'h0, 1'b0, st);
      check("miss_penalty", st, 9);
      check("miss_fill_count", n_fill - f0, 4);
      check("miss_mark_count", n_mark - m0, 1);
      for (int k = 0; k < 4; k++)
         check("miss_fill_order", (l0 + k < fill_log.size()) ? fill_log[l0 + k] : 32'hX,
               exp_order[k]);

      // Store hit with ready held low for 3 cycles.
      ready_delay = 3; r0 = n_req_cycles; w0 = n_wr; f0 = n_fill;
      exp_req.push_back('{1'b1, 32'h0000_0100, 32'hDEAD_BEEF});
      access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, st);
      check("store_stalls", st, 5);
      check("store_req_cycles", n_req_cycles - r0, 4);
      check("store_single_write", n_wr - w0, 1);
      check("store_no_fill", n_fill - f0, 0);

      // Store miss: one write, no allocation.
      ready_delay = 0; w0 = n_wr; f0 = n_fill;
      exp_req.push_back('{1'b1, 32'h0000_0204, 32'h1234_5678});
      access(1'b1, 32'h0000_0204, 32'h1234_5678, 1'b0, st);
      check("store_miss_stalls", st, 2);
      check("store_miss_write", n_wr - w0, 1);
      check("store_miss_no_fill", n_fill - f0, 0);

      // Read miss with 2 wait cycles per request.
      ready_delay = 2; f0 = n_fill; m0 = n_mark;
      push_read_miss(32'h0000_ABC4);
      access(1'b0, 32'h0000_ABC4, 32'h0, 1'b0, st);
      check("slow_miss_penalty", st, 17);
      check("slow_miss_fills", n_fill - f0, 4);
      check("slow_miss_mark", n_mark - m0, 1);

      // Reset after the 2nd fill word; a stray response afterwards must not fill.
      ready_delay = 0; f0 = n_fill; m0 = n_mark;
      push_read_miss(32'h0000_2008);
      @(posedge clk); #1;
      mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_2008; cache_hit = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (n_fill - f0 == 2) begin
            got = 1'b1;
            break;
         end
      end
      check("rst_reached_2nd_fill", got, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; mem_valid = 1'b0;
      @(negedge clk);
      check("rst_stall", stall, 1'b0);
      check("rst_req_valid", bus_req_valid, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; inject_cnt++;
      @(negedge clk);
      check("stray_resp_no_fill", fill_en, 1'b0);
      check("post_rst_stall", stall, 1'b0);
      check("post_rst_req_valid", bus_req_valid, 1'b0);
      check("rst_no_mark", n_mark - m0, 0);
      check("rst_fill_count", n_fill - f0, 2);

      // Normal operation after reset.
      access(1'b0, 32'h0000_2008, 32'h0, 1'b1, st);
      check("post_rst_hit_stalls", st, 0);

      repeat (2) @(negedge clk);
      check("model_req_drained", exp_req.size(), 0);
      check("model_fill_drained", exp_fill.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
